// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// Handshake: a byte transfers on a rising edge where in_valid && in_ready; in_data is ignored otherwise.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: reads a length-prefixed little-endian byte stream and writes 32-bit words
// to consecutive instruction-memory addresses from 0, holding the CPU in reset meanwhile.
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    imem_loader_if.slave      bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_written,
    output logic [2:0]        state_o
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [16:0] MAX_W17 = 17'(MAX_WORDS);

    state_t            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [23:0]       asm_q, asm_d;
    logic [1:0]        idx_q, idx_d;
    logic [ADDR_W:0]   ww_q, ww_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              in_ready_c;
    logic              accept;
    logic [15:0]       n_full;
    logic [ADDR_W:0]   ww_inc;

    assign in_ready_c = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
    assign accept     = bus.in_valid && in_ready_c;
    assign n_full     = {bus.in_data, len_lo_q};
    assign ww_inc     = ww_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        asm_d    = asm_q;
        idx_d    = idx_q;
        ww_d     = ww_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN_LO;
                    ww_d    = '0;
                    idx_d   = '0;
                    asm_d   = '0;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_lo_d = bus.in_data;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d = n_full[ADDR_W:0];
                    if (n_full == 16'd0)
                        state_d = S_DONE;
                    else if ({1'b0, n_full} > MAX_W17)
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    idx_d = idx_q + 2'd1;
                    case (idx_q)
                        2'd0: asm_d[7:0]   = bus.in_data;
                        2'd1: asm_d[15:8]  = bus.in_data;
                        2'd2: asm_d[23:16] = bus.in_data;
                        default: begin
                            // Fourth byte: the word bypasses asm_q straight into the write register.
                            we_d    = 1'b1;
                            addr_d  = ww_q[ADDR_W-1:0];
                            wdata_d = {bus.in_data, asm_q};
                            ww_d    = ww_inc;
                            if (ww_inc == len_q)
                                state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q  <= S_IDLE;
            len_lo_q <= '0;
            len_q    <= '0;
            asm_q    <= '0;
            idx_q    <= '0;
            ww_q     <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            asm_q    <= asm_d;
            idx_q    <= idx_d;
            ww_q     <= ww_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign busy          = in_ready_c;
    assign cpu_hold      = in_ready_c || (state_q == S_DONE) || (state_q == S_ERR);
    assign done          = (state_q == S_DONE);
    assign err           = (state_q == S_ERR);
    assign words_written = ww_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of loads plus random loads checked against a word-list model,
// and hand-written sequences for latency, valid gaps and mid-load reset.
module tb_imem_loader;
  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;
  localparam int W         = ADDR_W + 32;

  logic              clk;
  logic              res;
  logic              start;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_written;
  logic [2:0]        state_o;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk           (clk),
    .res           (res),
    .start         (start),
    .bus           (bus),
    .cpu_hold      (cpu_hold),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .words_written (words_written),
    .state_o       (state_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [W-1:0] exp_q[$];
  int           we_cyc_q[$];

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // scoreboard: every write must match the next expected {addr, word}
  always @(negedge clk) begin
    if (res && bus.mem_we === 1'b1) begin
      we_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {bus.mem_addr, bus.mem_wdata}, '0);
      end else begin
        chk("write", {bus.mem_addr, bus.mem_wdata}, exp_q.pop_front());
        chk("write_ww", 64'(words_written), 64'(bus.mem_addr) + 64'd1);
      end
    end
  end

  // driver tasks: all entered and left #1 after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gmin, input int gmax, input bit noise);
    int n;
    repeat ($urandom_range(gmax, gmin)) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom());
      tick();
    end
    start        = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.in_ready) chk("accept_timeout", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    start        = 1'b0;
  endtask

  // model: a load of n words is a list of n random words written to addresses 0..n-1,
  // streamed little-endian after a 16-bit count; counts above MAX_WORDS write nothing.
  task automatic run_load(input int n, input int gmin, input int gmax, input bit noise);
    logic [31:0] w;
    pulse_start();
    chk("lenlo_busy", 64'(busy), 64'd1);
    chk("lenlo_hold", 64'(cpu_hold), 64'd1);
    chk("lenlo_err", 64'(err), 64'd0);
    chk("lenlo_ww", 64'(words_written), 64'd0);
    chk("lenlo_ready", 64'(bus.in_ready), 64'd1);
    send_byte(8'(n), gmin, gmax, noise);
    send_byte(8'(n >> 8), gmin, gmax, noise);
    if (n > MAX_WORDS) begin
      chk("err_err", 64'(err), 64'd1);
      chk("err_ready", 64'(bus.in_ready), 64'd0);
      chk("err_busy", 64'(busy), 64'd0);
      chk("err_hold", 64'(cpu_hold), 64'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom());
      tick();
      tick();
      bus.in_valid = 1'b0;
      chk("err_sticky", 64'(err), 64'd1);
      chk("err_hold2", 64'(cpu_hold), 64'd1);
    end else begin
      for (int i = 0; i < n; i++) begin
        w = $urandom();
        exp_q.push_back({ADDR_W'(i), w});
        for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], gmin, gmax, noise);
      end
      chk("done_pulse", 64'(done), 64'd1);
      chk("done_we", 64'(bus.mem_we), (n > 0) ? 64'd1 : 64'd0);
      chk("done_busy", 64'(busy), 64'd0);
      chk("done_hold", 64'(cpu_hold), 64'd1);
      chk("done_ww", 64'(words_written), 64'(n));
      chk("done_ready", 64'(bus.in_ready), 64'd0);
      tick();
      chk("idle_done", 64'(done), 64'd0);
      chk("idle_hold", 64'(cpu_hold), 64'd0);
      chk("idle_we", 64'(bus.mem_we), 64'd0);
      chk("all_written", 64'(exp_q.size()), 64'd0);
    end
  endtask

  typedef struct {
    int n;
    int gmin;
    int gmax;
    bit noise;
    bit exp_err;
    int exp_ww;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int c0;
    int n;
    logic [7:0] pb[10];
    vecs[0] = '{0,     0, 0, 1'b0, 1'b0, 0};
    vecs[1] = '{1,     0, 0, 1'b0, 1'b0, 1};
    vecs[2] = '{1,     1, 1, 1'b0, 1'b0, 1};
    vecs[3] = '{3,     0, 2, 1'b1, 1'b0, 3};
    vecs[4] = '{1025,  0, 0, 1'b0, 1'b1, 0};
    vecs[5] = '{1,     0, 0, 1'b0, 1'b0, 1};
    vecs[6] = '{65535, 0, 1, 1'b1, 1'b1, 0};
    vecs[7] = '{16,    0, 3, 1'b1, 1'b0, 16};
    vecs[8] = '{1024,  0, 0, 1'b1, 1'b0, 1024};

    // reset
    res = 1'b0; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (3) tick();
    chk("rst_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_we", 64'(bus.mem_we), 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_flags", {cpu_hold, busy, done, err}, 64'd0);
    chk("rst_ww", 64'(words_written), 64'd0);
    res = 1'b1;
    tick();
    chk("idle_ignores_valid", 64'(bus.in_ready), 64'd0);

    // reference program N=2: latency and exact words
    pb = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    exp_q.push_back({ADDR_W'(0), 32'h0000_0013});
    exp_q.push_back({ADDR_W'(1), 32'h0010_0093});
    we_cyc_q.delete();
    c0 = cyc;
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(pb[i], 0, 0, 1'b0);
    chk("n2_done_cycle", 64'(cyc - c0), 64'd11);
    chk("n2_done", 64'(done), 64'd1);
    chk("n2_ww", 64'(words_written), 64'd2);
    tick();
    chk("n2_hold_falls", 64'(cpu_hold), 64'd0);
    chk("n2_we_count", 64'(we_cyc_q.size()), 64'd2);
    if (we_cyc_q.size() == 2) begin
      chk("n2_first_we_cycle", 64'(we_cyc_q[0] - c0), 64'd7);
      chk("n2_last_we_cycle", 64'(we_cyc_q[1] - c0), 64'd11);
    end

    // table-driven loads
    foreach (vecs[k]) begin
      run_load(vecs[k].n, vecs[k].gmin, vecs[k].gmax, vecs[k].noise);
      chk($sformatf("vec%0d_err", k), 64'(err), 64'(vecs[k].exp_err));
      chk($sformatf("vec%0d_ww", k), 64'(words_written), 64'(vecs[k].exp_ww));
    end

    // random loads
    for (int r = 0; r < 6; r++) begin
      n = ($urandom_range(0, 5) == 0) ? 1025 + $urandom_range(0, 3000) : $urandom_range(0, 24);
      run_load(n, 0, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      chk($sformatf("rnd%0d_err", r), 64'(err), (n > MAX_WORDS) ? 64'd1 : 64'd0);
      chk($sformatf("rnd%0d_ww", r), 64'(words_written), (n > MAX_WORDS) ? 64'd0 : 64'(n));
    end

    // reset on the cycle the 4th byte of word 5 is accepted
    pulse_start();
    send_byte(8'd8, 0, 0, 1'b0);
    send_byte(8'd0, 0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] w;
      w = $urandom();
      exp_q.push_back({ADDR_W'(i), w});
      for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], 0, 0, 1'b0);
    end
    for (int j = 0; j < 3; j++) send_byte(8'($urandom()), 0, 0, 1'b0);
    chk("pre_rst_ready", 64'(bus.in_ready), 64'd1);
    bus.in_data  = 8'hA5;
    bus.in_valid = 1'b1;
    res          = 1'b0;
    tick();
    res          = 1'b1;
    bus.in_valid = 1'b0;
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_we", 64'(bus.mem_we), 64'd0);
    chk("mid_rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("mid_rst_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("mid_rst_flags", {cpu_hold, busy, done, err}, 64'd0);
    chk("mid_rst_ww", 64'(words_written), 64'd0);
    chk("mid_rst_pending", 64'(exp_q.size()), 64'd0);
    repeat (3) begin
      tick();
      chk("post_rst_no_we", 64'(bus.mem_we), 64'd0);
    end

    // a load after the aborted one starts cleanly
    run_load(2, 0, 1, 1'b0);
    chk("after_rst_ww", 64'(words_written), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
